// File: rtl/sd_cmd_tx_if.sv
// rtl/sd_cmd_tx_if.sv - command request/response bundle between host logic and sd_cmd_tx
interface sd_cmd_tx_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        done;
  logic [7:0]  r1;
  logic        timeout;

  modport master (
    output start, cmd_index, cmd_arg,
    input  busy, done, r1, timeout
  );

  modport slave (
    input  start, cmd_index, cmd_arg,
    output busy, done, r1, timeout
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - SPI-mode SD command transmitter with R1 response capture
module sd_cmd_tx #(
  parameter int PREAMBLE     = 8,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      rst,
  sd_cmd_tx_if.slave cmd,
  input  logic      sd_miso,
  output logic      sd_cs_n,
  output logic      sd_mosi,
  output logic      resp_flag
);

  localparam int FRAME_BITS = 48;
  localparam int CNT_MAX_A  = (PREAMBLE > FRAME_BITS) ? PREAMBLE : FRAME_BITS;
  localparam int CNT_MAX    = (RESP_TIMEOUT > CNT_MAX_A) ? RESP_TIMEOUT : CNT_MAX_A;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE - 1);
  localparam logic [CW-1:0] SEND_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] RECV_LAST = CW'(6);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SEND,
    WAIT,
    RECV,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [47:0]   frame_q;
  logic [6:0]    rx_q;
  logic [7:0]    r1_q;
  logic          timeout_q;
  logic          busy_c;
  logic          done_c;
  logic [39:0]   hdr_c;

  // CRC7 (x^7 + x^3 + 1, zero seed) over the 40 header bits, MSB first
  function automatic logic [6:0] crc7_40(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int k = 39; k >= 0; k--) begin
      fb = bits[k] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  assign hdr_c       = {2'b01, cmd.cmd_index, cmd.cmd_arg};
  assign cmd.busy    = busy_c;
  assign cmd.done    = done_c;
  assign cmd.r1      = r1_q;
  assign cmd.timeout = timeout_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state
  always_comb begin
    state_d   = state_q;
    sd_cs_n   = 1'b1;
    sd_mosi   = 1'b1;
    resp_flag = 1'b0;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (cmd.start) begin
          state_d = PRE;
        end
      end
      PRE: begin
        sd_cs_n = 1'b0;
        if (cnt_q == PRE_LAST) begin
          state_d = SEND;
        end
      end
      SEND: begin
        sd_cs_n = 1'b0;
        sd_mosi = frame_q[47];
        if (cnt_q == SEND_LAST) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        sd_cs_n   = 1'b0;
        resp_flag = 1'b1;
        // A start bit on the last allowed cycle still counts as a response
        if (!sd_miso) begin
          state_d = RECV;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = DONE;
        end
      end
      RECV: begin
        sd_cs_n   = 1'b0;
        resp_flag = 1'b1;
        if (cnt_q == RECV_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_c  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Per-state cycle counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) begin
      cnt_q <= '0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Frame shifter and response capture; r1/timeout only change on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= '0;
      rx_q      <= '0;
      r1_q      <= 8'hFF;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd.start) begin
            frame_q <= {hdr_c, crc7_40(hdr_c), 1'b1};
          end
        end
        SEND: begin
          frame_q <= {frame_q[46:0], 1'b0};
        end
        WAIT: begin
          if (!sd_miso) begin
            rx_q <= 7'h00;
          end else if (cnt_q == WAIT_LAST) begin
            r1_q      <= 8'hFF;
            timeout_q <= 1'b1;
          end
        end
        RECV: begin
          rx_q <= {rx_q[5:0], sd_miso};
          if (cnt_q == RECV_LAST) begin
            r1_q      <= {rx_q, sd_miso};
            timeout_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb/tb_sd_cmd_tx.sv - directed self-checking bench for sd_cmd_tx
module tb_sd_cmd_tx;

  localparam int P  = 8;
  localparam int RT = 64;

  logic clk;
  logic rst;
  logic sd_miso;
  logic sd_cs_n;
  logic sd_mosi;
  logic resp_flag;

  int tests;
  int fails;

  sd_cmd_tx_if bus ();

  sd_cmd_tx #(
    .PREAMBLE    (P),
    .RESP_TIMEOUT(RT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (bus.slave),
    .sd_miso  (sd_miso),
    .sd_cs_n  (sd_cs_n),
    .sd_mosi  (sd_mosi),
    .resp_flag(resp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One command transaction; w = start-bit WAIT cycle number (1-based), 0 = card never answers
  task automatic xact(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                      input logic [47:0] exp_frame, input int w, input logic [7:0] resp,
                      input bit pulse_start);
    int          i;
    int          j;
    int          done_at;
    int          done_exp;
    int          pre_bad;
    int          rf_bad;
    int          cs_bad;
    logic        exp_rf;
    logic        exp_cs;
    logic [47:0] fr;
    logic [7:0]  r1_s;
    logic        to_s;
    bit          tmo;
    tmo      = (w == 0);
    done_exp = tmo ? (P + 49 + RT) : (P + 56 + w);
    done_at  = -1;
    pre_bad  = 0;
    rf_bad   = 0;
    cs_bad   = 0;
    fr       = '0;
    r1_s     = 8'h00;
    to_s     = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'(1'b0));
    check({tag, "_idle_done"}, 64'(bus.done), 64'(1'b0));
    bus.start     = 1'b1;
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    sd_miso       = 1'b1;
    i = 0;
    while (done_at < 0 && i < 400) begin
      @(negedge clk);
      i++;
      bus.start     = pulse_start && (i == P + 10 || i == P + 30);
      bus.cmd_index = 6'h3F;
      bus.cmd_arg   = 32'hFFFF_FFFF;
      if (!tmo && i == P + 48 + w) begin
        sd_miso = 1'b0;
      end else if (!tmo && i > P + 48 + w && i <= P + 55 + w) begin
        j = P + 55 + w - i;
        sd_miso = resp[3'(j)];
      end else begin
        sd_miso = 1'b1;
      end
      if (i >= 1 && i <= P) begin
        if (sd_cs_n !== 1'b0 || sd_mosi !== 1'b1) pre_bad++;
      end
      if (i > P && i <= P + 48) begin
        fr = {fr[46:0], sd_mosi};
      end
      exp_rf = (i >= P + 49) && (i < done_exp);
      exp_cs = (i < done_exp) ? 1'b0 : 1'b1;
      if (resp_flag !== exp_rf) rf_bad++;
      if (sd_cs_n !== exp_cs) cs_bad++;
      if (bus.done === 1'b1) begin
        done_at = i;
        r1_s    = bus.r1;
        to_s    = bus.timeout;
      end
    end
    sd_miso = 1'b1;
    check({tag, "_done_cycle"}, 64'(done_at), 64'(done_exp));
    check({tag, "_preamble"}, 64'(pre_bad), 64'(0));
    check({tag, "_frame"}, 64'(fr), 64'(exp_frame));
    check({tag, "_resp_flag"}, 64'(rf_bad), 64'(0));
    check({tag, "_cs_n"}, 64'(cs_bad), 64'(0));
    check({tag, "_r1"}, 64'(r1_s), tmo ? 64'(8'hFF) : 64'(resp));
    check({tag, "_timeout"}, 64'(to_s), 64'(tmo));
    if (!tmo) begin
      check({tag, "_length"}, 64'(done_at + 1), 64'(1 + P + 48 + w + 7 + 1));
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    sd_miso       = 1'b1;
    bus.start     = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;

    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(sd_cs_n), 64'(1'b1));
    check("rst_mosi", 64'(sd_mosi), 64'(1'b1));
    check("rst_resp_flag", 64'(resp_flag), 64'(1'b0));
    check("rst_busy", 64'(bus.busy), 64'(1'b0));
    check("rst_done", 64'(bus.done), 64'(1'b0));
    check("rst_r1", 64'(bus.r1), 64'(8'hFF));
    check("rst_timeout", 64'(bus.timeout), 64'(1'b0));
    rst = 1'b0;

    xact("cmd0", 6'd0, 32'h0000_0000, 48'h40_0000_0000_95, 4, 8'h01, 1'b0);
    xact("cmd8_w1", 6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 1, 8'h01, 1'b0);
    xact("cmd55_pulse", 6'd55, 32'h0000_0000, 48'h77_0000_0000_65, RT - 1, 8'h5A, 1'b1);
    xact("cmd41_b2b", 6'd41, 32'h4000_0000, 48'h69_4000_0000_77, 2, 8'h00, 1'b0);
    xact("cmd0_tmo", 6'd0, 32'h0000_0000, 48'h40_0000_0000_95, 0, 8'h00, 1'b0);
    xact("cmd8_after_tmo", 6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 2, 8'h05, 1'b0);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.cmd_index = 6'd0;
    bus.cmd_arg   = 32'h0;
    for (int k = 1; k <= P + 21; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 64'(sd_cs_n), 64'(1'b1));
    check("midrst_busy", 64'(bus.busy), 64'(1'b0));
    check("midrst_done", 64'(bus.done), 64'(1'b0));
    check("midrst_resp_flag", 64'(resp_flag), 64'(1'b0));
    check("midrst_r1", 64'(bus.r1), 64'(8'hFF));
    rst = 1'b0;
    xact("cmd0_after_rst", 6'd0, 32'h0000_0000, 48'h40_0000_0000_95, 3, 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_cmd_tx.md
SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 Parameter: PREAMBLE, default 8, number of MOSI-high fill bits sent with CS low before each command frame.
REQ-002 Parameter: RESP_TIMEOUT, default 64, maximum number of WAIT cycles spent looking for a response start bit.
REQ-003 clk  input  1  system clock, rising-edge; one SD bit per clk cycle.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  one-cycle command request; honoured only in IDLE.
REQ-006 cmd_index  input  6  SD command number, latched on an accepted start.
REQ-007 cmd_arg  input  32  command argument, latched on an accepted start.
REQ-008 sd_miso  input  1  serial response bit from the card.
REQ-009 sd_cs_n  output  1  card select, active-low.
REQ-010 sd_mosi  output  1  serial command bit to the card, MSB first.
REQ-011 resp_flag  output  1  response window; high in WAIT and RECV, drives the downstream response capture stage.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse marking the end of a transaction.
REQ-014 r1  output  8  captured R1 response byte, valid when done is high, held until the next done.
REQ-015 timeout  output  1  set with done when no start bit arrived, held until the next done.

Function
REQ-016 The FSM SHALL use states IDLE, PRE, SEND, WAIT, RECV and DONE.
REQ-017 IDLE with start=1 SHALL latch cmd_index and cmd_arg, enter PRE on the next cycle and assert busy.
REQ-018 start SHALL be ignored while busy=1, with no effect on the transaction in progress.
REQ-019 PRE SHALL drive sd_cs_n=0 and sd_mosi=1 for exactly PREAMBLE cycles, then enter SEND.
REQ-020 The frame SHALL be {2'b01, cmd_index, cmd_arg, crc7, 1'b1}, 48 bits.
REQ-021 crc7 SHALL use polynomial x^7+x^3+1 with zero initial value over the first 40 frame bits.
REQ-022 The CRC SHALL be complete before the first crc7 bit is driven, by serial or combinational computation.
REQ-023 SEND SHALL drive one frame bit per cycle MSB first for exactly 48 cycles, then enter WAIT.
REQ-024 WAIT SHALL drive sd_mosi=1 and resp_flag=1, sample sd_miso each cycle and count cycles from 0.
REQ-025 sd_miso=0 in WAIT SHALL store that 0 as r1[7] and enter RECV.
REQ-026 If the WAIT count reaches RESP_TIMEOUT with no 0 sampled, the FSM SHALL enter DONE with r1 set to 8'hFF and timeout set to 1.
REQ-027 RECV SHALL shift in 7 further sd_miso bits, r1[6] down to r1[0], one per cycle, then enter DONE.
REQ-028 DONE SHALL last one cycle with sd_cs_n=1, resp_flag=0 and done=1, then return to IDLE.
REQ-029 busy SHALL drop in the IDLE cycle that follows DONE.
REQ-030 timeout SHALL be 0 on a normal completion.
REQ-031 A start asserted in the cycle after DONE SHALL be accepted.
REQ-032 Outside PRE, SEND, WAIT and RECV, sd_cs_n and sd_mosi SHALL be 1.
REQ-033 resp_flag SHALL be 0 in all states other than WAIT and RECV.
REQ-034 Transaction length SHALL be 1 (IDLE accept) + PREAMBLE + 48 + W + 7 + 1 cycles, where W = WAIT cycles including the start-bit cycle.

Reset
REQ-035 rst=1 SHALL force IDLE on the next clock, including mid-transaction, with no done pulse generated.
REQ-036 Reset values SHALL be sd_cs_n=1, sd_mosi=1, resp_flag=0, busy=0, done=0, r1=8'hFF, timeout=0.
REQ-037 All counters and latched command fields SHALL clear on reset.

Verification
REQ-038 CMD0, arg 0 -> MOSI after the preamble SHALL be 40 00 00 00 00 95; miso goes 0 after 3 WAIT cycles with byte 0x01 -> done, r1=0x01, timeout=0.
REQ-039 CMD8, arg 0x000001AA -> MOSI SHALL be 48 00 00 01 AA 87 (crc7=0x43).
REQ-040 sd_miso held 1 -> done exactly RESP_TIMEOUT cycles after WAIT entry, r1=0xFF, timeout=1.
REQ-041 start pulsed during SEND -> frame unchanged and exactly one done pulse; start in the cycle after DONE -> new transaction begins.
REQ-042 rst asserted on SEND bit 20 -> next cycle IDLE with sd_cs_n=1 and busy=0, no done; a following CMD0 completes normally.
REQ-043 Check resp_flag=1 on exactly the WAIT and RECV cycles and total cycle count per REQ-034 for W=1 and W=RESP_TIMEOUT-1.
